// File: rtl/fpu_sched_pkg.sv
// rtl/fpu_sched_pkg.sv - shared types and constants for the FP add sequencer
package fpu_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } sched_state_e;

  // EXEC_CYCLES must lie in this range; the window counter is sized for the max.
  localparam int EXEC_CYCLES_MIN = 1;
  localparam int EXEC_CYCLES_MAX = 15;
  localparam int CNT_W           = 4;

endpackage

// File: rtl/fpu_fpd_add_core.sv
// rtl/fpu_fpd_add_core.sv - combinational IEEE double add/sub core
module fpu_fpd_add_core (
  input  logic        en,
  input  logic        sub,
  input  logic [63:0] srca,
  input  logic [63:0] srcb,
  output logic [63:0] dst
);

  logic               sa, sb, sx, sy, swap, found, up;
  logic [10:0]        ea, eb, ex, ey, d;
  logic [52:0]        ma, mb, mx, my;
  logic [55:0]        ax, ay, aln, lost_mask, norm;
  logic [56:0]        sum;
  logic [5:0]         lz;
  logic signed [12:0] e_res;
  logic [53:0]        mant_r;

  // Align, add, normalise, round-to-nearest-even; subnormals flush to zero,
  // exponent overflow saturates to infinity. Output is zero while disabled.
  always_comb begin
    sa = srca[63];
    sb = srcb[63] ^ sub;
    ea = srca[62:52];
    eb = srcb[62:52];
    ma = (ea == 11'd0) ? 53'd0 : {1'b1, srca[51:0]};
    mb = (eb == 11'd0) ? 53'd0 : {1'b1, srcb[51:0]};
    swap = {eb, mb} > {ea, ma};
    sx = swap ? sb : sa;
    sy = swap ? sa : sb;
    ex = swap ? eb : ea;
    ey = swap ? ea : eb;
    mx = swap ? mb : ma;
    my = swap ? ma : mb;
    d  = ex - ey;
    ax = {mx, 3'b000};
    ay = {my, 3'b000};
    lost_mask = ~({56{1'b1}} << d);
    if (d > 11'd55) aln = {55'd0, |ay};
    else            aln = (ay >> d) | {55'd0, |(ay & lost_mask)};
    sum = (sx == sy) ? ({1'b0, ax} + {1'b0, aln}) : ({1'b0, ax} - {1'b0, aln});
    e_res = $signed({2'b00, ex});
    lz    = 6'd0;
    found = 1'b0;
    for (int i = 55; i >= 0; i--) begin
      if (!found) begin
        if (sum[i]) found = 1'b1;
        else        lz = lz + 6'd1;
      end
    end
    if (sum[56]) begin
      norm  = {sum[56:2], sum[1] | sum[0]};
      e_res = e_res + 13'sd1;
    end else begin
      norm  = sum[55:0] << lz;
      e_res = e_res - $signed({7'd0, lz});
    end
    up     = norm[2] & (norm[3] | norm[1] | norm[0]);
    mant_r = {1'b0, norm[55:3]} + {53'd0, up};
    if (mant_r[53]) e_res = e_res + 13'sd1;

    if (!en) begin
      dst = 64'd0;
    end else if (ea == 11'h7ff || eb == 11'h7ff) begin
      if ((ea == 11'h7ff && srca[51:0] != 52'd0) || (eb == 11'h7ff && srcb[51:0] != 52'd0) ||
          (ea == 11'h7ff && eb == 11'h7ff && sa != sb))
        dst = 64'h7FF8_0000_0000_0000;
      else if (ea == 11'h7ff)
        dst = {sa, 11'h7ff, 52'd0};
      else
        dst = {sb, 11'h7ff, 52'd0};
    end else if (sum == 57'd0) begin
      dst = {sx & sy, 63'd0};
    end else if (e_res <= 13'sd0) begin
      dst = {sx, 63'd0};
    end else if (e_res >= 13'sd2047) begin
      dst = {sx, 11'h7ff, 52'd0};
    end else begin
      dst = {sx, e_res[10:0], mant_r[53] ? mant_r[52:1] : mant_r[51:0]};
    end
  end

endmodule

// File: rtl/fpu_rr_arb2.sv
// rtl/fpu_rr_arb2.sv - two-way round-robin arbiter, combinational
module fpu_rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic       en,
  output logic [1:0] grant_oh
);

  // A lone requester wins outright; on a tie the port not granted last time wins.
  always_comb begin
    grant_oh = 2'b00;
    if (en) begin
      case (valid)
        2'b01:   grant_oh = 2'b01;
        2'b10:   grant_oh = 2'b10;
        2'b11:   grant_oh = last_grant ? 2'b01 : 2'b10;
        default: grant_oh = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/fpu_fpd_add_sched.sv
// rtl/fpu_fpd_add_sched.sv - two-port sequencer/arbiter around the shared FP add core
module fpu_fpd_add_sched
  import fpu_sched_pkg::*;
#(
  parameter int EXEC_CYCLES = 3,
  parameter int TAG_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_sub,
  input  logic [63:0]      req0_srca,
  input  logic [63:0]      req0_srcb,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_sub,
  input  logic [63:0]      req1_srca,
  input  logic [63:0]      req1_srcb,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [63:0]      res_data,
  output logic             res_port,
  output logic [TAG_W-1:0] res_tag,
  output logic             busy,
  output logic [31:0]      perf_ops
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(EXEC_CYCLES - 1);

  sched_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_grant_q, last_grant_d;
  logic             op_sub_q, op_sub_d, op_port_q, op_port_d;
  logic [63:0]      op_srca_q, op_srca_d, op_srcb_q, op_srcb_d;
  logic [TAG_W-1:0] op_tag_q, op_tag_d;
  logic             res_valid_q, res_valid_d, res_port_q, res_port_d;
  logic [63:0]      res_data_q, res_data_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d;
  logic [31:0]      perf_ops_q, perf_ops_d;
  logic             acc, hs, sel;
  logic [1:0]       grant_oh;
  logic [63:0]      core_dst;

  // Reset is excluded so a requester never sees a handshake the flops will drop.
  assign acc = !reset && !flush && (state_q == IDLE || (state_q == DONE && res_ready));

  fpu_rr_arb2 u_arb (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant_q),
    .en         (acc),
    .grant_oh   (grant_oh)
  );

  assign req0_ready = grant_oh[0];
  assign req1_ready = grant_oh[1];
  assign hs         = |grant_oh;
  assign sel        = grant_oh[1];

  // Core sees only the operand registers, so its inputs are stable across the window.
  fpu_fpd_add_core u_core (
    .en   (state_q == EXEC),
    .sub  (op_sub_q),
    .srca (op_srca_q),
    .srcb (op_srcb_q),
    .dst  (core_dst)
  );

  // Next-state: flush wins over everything except reset; a handshake may chain from DONE.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    op_sub_d     = op_sub_q;
    op_port_d    = op_port_q;
    op_srca_d    = op_srca_q;
    op_srcb_d    = op_srcb_q;
    op_tag_d     = op_tag_q;
    res_valid_d  = res_valid_q;
    res_port_d   = res_port_q;
    res_data_d   = res_data_q;
    res_tag_d    = res_tag_q;
    perf_ops_d   = perf_ops_q;
    if (flush) begin
      state_d     = IDLE;
      res_valid_d = 1'b0;
      cnt_d       = '0;
    end else begin
      case (state_q)
        EXEC: begin
          if (cnt_q == '0) begin
            res_data_d  = core_dst;
            res_tag_d   = op_tag_q;
            res_port_d  = op_port_q;
            res_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            perf_ops_d  = perf_ops_q + 32'd1;
            res_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
        default: ;
      endcase
      if (hs) begin
        op_sub_d     = sel ? req1_sub  : req0_sub;
        op_srca_d    = sel ? req1_srca : req0_srca;
        op_srcb_d    = sel ? req1_srcb : req0_srcb;
        op_tag_d     = sel ? req1_tag  : req0_tag;
        op_port_d    = sel;
        last_grant_d = sel;
        cnt_d        = CNT_INIT;
        state_d      = EXEC;
      end
    end
  end

  // State registers; last_grant resets to 1 so port 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      op_sub_q     <= 1'b0;
      op_port_q    <= 1'b0;
      op_srca_q    <= '0;
      op_srcb_q    <= '0;
      op_tag_q     <= '0;
      res_valid_q  <= 1'b0;
      res_port_q   <= 1'b0;
      res_data_q   <= '0;
      res_tag_q    <= '0;
      perf_ops_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      op_sub_q     <= op_sub_d;
      op_port_q    <= op_port_d;
      op_srca_q    <= op_srca_d;
      op_srcb_q    <= op_srcb_d;
      op_tag_q     <= op_tag_d;
      res_valid_q  <= res_valid_d;
      res_port_q   <= res_port_d;
      res_data_q   <= res_data_d;
      res_tag_q    <= res_tag_d;
      perf_ops_q   <= perf_ops_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_port  = res_port_q;
  assign res_tag   = res_tag_q;
  assign busy      = (state_q != IDLE);
  assign perf_ops  = perf_ops_q;

endmodule

// File: tb/tb_fpu_fpd_add_sched.sv
// tb/tb_fpu_fpd_add_sched.sv - scoreboard bench for the FP add sequencer
module tb_fpu_fpd_add_sched;

  localparam int EXEC_CYCLES = 3;
  localparam int TAG_W       = 4;

  logic             clk = 1'b0;
  logic             reset, flush, res_ready;
  logic             req0_valid, req0_ready, req0_sub, req1_valid, req1_ready, req1_sub;
  logic [63:0]      req0_srca, req0_srcb, req1_srca, req1_srcb, res_data;
  logic [TAG_W-1:0] req0_tag, req1_tag, res_tag;
  logic             res_valid, res_port, busy;
  logic [31:0]      perf_ops;

  typedef struct {
    logic [63:0]      data;
    logic             port;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0, n_err = 0, cyc = 0, hs_cyc = 0;
  logic [63:0] va[9], vb[9], vr[9];
  logic        vs[9];
  int          at, g, gp, i0, i1, last_hs;
  logic [31:0] perf_before;
  logic [63:0] snap_data;
  logic [TAG_W-1:0] snap_tag;
  logic        snap_port, stable, seen;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fpu_fpd_add_sched #(.EXEC_CYCLES(EXEC_CYCLES), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sub(req0_sub),
    .req0_srca(req0_srca), .req0_srcb(req0_srcb), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sub(req1_sub),
    .req1_srca(req1_srca), .req1_srcb(req1_srcb), .req1_tag(req1_tag),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_port(res_port), .res_tag(res_tag), .busy(busy), .perf_ops(perf_ops)
  );

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endfunction

  // Scoreboard monitor: every result handshake must match the oldest expected entry.
  always @(negedge clk) begin
    if (!reset && res_valid && res_ready) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexpected: got result %h, required none", res_data);
      end else begin
        e = exp_q.pop_front();
        check("res_data", res_data, e.data);
        check("res_port", 64'(res_port), 64'(e.port));
        check("res_tag", 64'(res_tag), 64'(e.tag));
      end
    end
  end

  task automatic drive_port(input int port, input int idx, input logic [TAG_W-1:0] tag, input logic v);
    if (port == 0) begin
      req0_valid = v; req0_sub = vs[idx]; req0_srca = va[idx]; req0_srcb = vb[idx]; req0_tag = tag;
    end else begin
      req1_valid = v; req1_sub = vs[idx]; req1_srca = va[idx]; req1_srcb = vb[idx]; req1_tag = tag;
    end
  endtask

  task automatic issue(input int port, input int idx, input logic [TAG_W-1:0] tag, input bit push);
    bit done = 1'b0;
    drive_port(port, idx, tag, 1'b1);
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      if ((port == 0) ? req0_ready : req1_ready) begin
        done   = 1'b1;
        hs_cyc = cyc;
        if (push) exp_q.push_back('{data: vr[idx], port: port[0], tag: tag});
      end
      @(posedge clk); #1;
    end
    if (port == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL issue_timeout: port %0d got no ready, required ready", port);
    end
  endtask

  task automatic wait_valid(output int when);
    when = -1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (res_valid) begin when = cyc; break; end
    end
    if (when < 0) begin
      n_vec++; n_err++;
      $display("FAIL wait_valid: res_valid stayed 0, required 1");
    end
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  initial begin
    // Directed vectors: operands, op, hand-computed double result.
    va[0] = 64'h3FF0000000000000; vb[0] = 64'h4000000000000000; vs[0] = 0; vr[0] = 64'h4008000000000000;
    va[1] = 64'h4008000000000000; vb[1] = 64'h3FF0000000000000; vs[1] = 1; vr[1] = 64'h4000000000000000;
    va[2] = 64'h3FF8000000000000; vb[2] = 64'h3FF8000000000000; vs[2] = 0; vr[2] = 64'h4008000000000000;
    va[3] = 64'h4000000000000000; vb[3] = 64'h4008000000000000; vs[3] = 1; vr[3] = 64'hBFF0000000000000;
    va[4] = 64'h3FF0000000000000; vb[4] = 64'h3FF0000000000000; vs[4] = 1; vr[4] = 64'h0000000000000000;
    va[5] = 64'h3FE0000000000000; vb[5] = 64'h3FD0000000000000; vs[5] = 0; vr[5] = 64'h3FE8000000000000;
    va[6] = 64'hC000000000000000; vb[6] = 64'hC000000000000000; vs[6] = 0; vr[6] = 64'hC010000000000000;
    va[7] = 64'h7FEFFFFFFFFFFFFF; vb[7] = 64'h7FEFFFFFFFFFFFFF; vs[7] = 0; vr[7] = 64'h7FF0000000000000;
    va[8] = 64'h7FF0000000000000; vb[8] = 64'h3FF0000000000000; vs[8] = 0; vr[8] = 64'h7FF0000000000000;

    reset = 1'b1; flush = 1'b0; res_ready = 1'b0;
    drive_port(0, 0, '0, 1'b1);
    drive_port(1, 0, '0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_data", res_data, 64'd0);
    check("rst_res_tag", 64'(res_tag), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_perf_ops", 64'(perf_ops), 64'd0);
    check("rst_no_ready", 64'(req0_ready), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0; req0_valid = 1'b0;

    // 1: port 0 1.0+2.0 with latency check
    res_ready = 1'b1;
    issue(0, 0, 4'h3, 1'b1);
    check("exec_busy", 64'(busy), 64'd1);
    wait_valid(at);
    check("latency", 64'(at - hs_cyc), 64'(EXEC_CYCLES + 1));
    wait_drain();

    // 2: port 1 3.0-1.0 tag A
    issue(1, 1, 4'hA, 1'b1);
    wait_drain();

    // 3: both ports continuously valid -> alternating grants at full throughput
    i0 = 2; i1 = 3; g = 0; last_hs = 0;
    drive_port(0, i0, 4'(i0), 1'b1);
    drive_port(1, i1, 4'(i1), 1'b1);
    for (int n = 0; n < 100 && g < 6; n++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        check("ready_onehot", 64'(req0_ready & req1_ready), 64'd0);
        gp = req1_ready ? 1 : 0;
        check("grant_order", 64'(gp), 64'(g % 2));
        if (g > 0) check("grant_gap", 64'(cyc - last_hs), 64'(EXEC_CYCLES + 1));
        last_hs = cyc;
        if (gp == 1) begin
          exp_q.push_back('{data: vr[i1], port: 1'b1, tag: 4'(i1)}); i1 += 2;
        end else begin
          exp_q.push_back('{data: vr[i0], port: 1'b0, tag: 4'(i0)}); i0 += 2;
        end
        g++;
      end
      @(posedge clk); #1;
      if (g < 6) begin
        drive_port(0, i0, 4'(i0), 1'b1);
        drive_port(1, i1, 4'(i1), 1'b1);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("grant_count", 64'(g), 64'd6);
    wait_drain();

    // 4: hold result in DONE, then same-cycle accept on res_ready
    res_ready = 1'b0;
    issue(0, 8, 4'h5, 1'b1);
    wait_valid(at);
    snap_data = res_data; snap_tag = res_tag; snap_port = res_port;
    @(posedge clk); #1;
    drive_port(0, 0, 4'h6, 1'b1);
    drive_port(1, 1, 4'h7, 1'b1);
    stable = 1'b1; seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (!res_valid || res_data !== snap_data || res_tag !== snap_tag || res_port !== snap_port) stable = 1'b0;
      if (req0_ready || req1_ready) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("done_hold_stable", 64'(stable), 64'd1);
    check("done_readies_low", 64'(seen), 64'd0);
    perf_before = perf_ops;
    req1_valid = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    check("same_cycle_accept", 64'(req0_ready), 64'd1);
    if (req0_ready) exp_q.push_back('{data: vr[0], port: 1'b0, tag: 4'h6});
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    check("perf_inc", 64'(perf_ops), 64'(perf_before + 32'd1));
    check("chained_busy", 64'(busy), 64'd1);
    wait_drain();

    // 5: flush during the second EXEC cycle
    perf_before = perf_ops;
    issue(0, 0, 4'h9, 1'b0);
    @(posedge clk); #1;
    flush = 1'b1;
    drive_port(1, 1, 4'hB, 1'b1);
    @(negedge clk);
    check("flush_blocks_ready", 64'(req1_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    check("flush_idle", 64'(busy), 64'd0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    check("flush_no_result", 64'(seen), 64'd0);
    check("flush_perf_same", 64'(perf_ops), 64'(perf_before));
    @(posedge clk); #1;
    issue(1, 1, 4'hC, 1'b1);
    wait_drain();

    // 6: reset while a result is held, tie arbitration after reset, perf wrap
    res_ready = 1'b0;
    issue(0, 0, 4'hD, 1'b1);
    wait_valid(at);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_res_valid", 64'(res_valid), 64'd0);
    check("mid_rst_res_data", res_data, 64'd0);
    check("mid_rst_res_tag", 64'(res_tag), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_perf", 64'(perf_ops), 64'd0);
    @(posedge clk); #1;
    res_ready = 1'b1;
    drive_port(0, 0, 4'h1, 1'b1);
    drive_port(1, 1, 4'h2, 1'b1);
    @(negedge clk);
    check("tie_after_reset", 64'({req1_ready, req0_ready}), 64'd1);
    if (req0_ready) exp_q.push_back('{data: vr[0], port: 1'b0, tag: 4'h1});
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_drain();
    @(negedge clk);
    force dut.perf_ops_q = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut.perf_ops_q;
    @(negedge clk);
    check("perf_preset", 64'(perf_ops), 64'hFFFF_FFFF);
    @(posedge clk); #1;
    issue(1, 1, 4'h4, 1'b1);
    wait_drain();
    @(negedge clk);
    check("perf_wrap", 64'(perf_ops), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
